// File: rtl/byte_set_pkg.sv
// Shared types and default sizing for the byte set scanner.
package byte_set_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned SET_DEPTH = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/byte_set_lookup.sv
// Combinational set-membership test: hit when any valid entry equals the byte.
module byte_set_lookup #(
  parameter int unsigned DATA_W    = byte_set_pkg::DATA_W,
  parameter int unsigned SET_DEPTH = byte_set_pkg::SET_DEPTH
) (
  input  logic [DATA_W-1:0]                 data,
  input  logic [SET_DEPTH-1:0][DATA_W-1:0]  set_val,
  input  logic [SET_DEPTH-1:0]              set_vld,
  output logic                              hit_c
);

  always_comb begin
    hit_c = 1'b0;
    for (int i = 0; i < int'(SET_DEPTH); i++) begin
      if (set_vld[i] && (set_val[i] == data)) begin
        hit_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/byte_set_scanner.sv
// Frame scanner: flags stream bytes that belong to a programmable byte set and
// reports hit count, first hit index and an end-of-frame done pulse.
module byte_set_scanner #(
  parameter int unsigned DATA_W    = byte_set_pkg::DATA_W,
  parameter int unsigned SET_DEPTH = byte_set_pkg::SET_DEPTH,
  parameter int unsigned IDX_W     = byte_set_pkg::IDX_W,
  parameter int unsigned LEN_W     = byte_set_pkg::LEN_W,
  parameter int unsigned CNT_W     = byte_set_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_clr,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_val,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              match_out,
  output logic [CNT_W-1:0]  hit_count,
  output logic [LEN_W-1:0]  first_hit_idx,
  output logic              first_hit_vld,
  output logic              done
);

  import byte_set_pkg::state_e;
  import byte_set_pkg::IDLE;
  import byte_set_pkg::SCAN;
  import byte_set_pkg::DONE;

  state_e state, state_n;

  logic [SET_DEPTH-1:0][DATA_W-1:0] set_val;
  logic [SET_DEPTH-1:0]             set_vld;
  logic [LEN_W-1:0]                 len_q;
  logic [LEN_W-1:0]                 idx_q;

  logic hit_c;
  logic accept_c;
  logic last_c;
  logic frame_start_c;
  logic cfg_open_c;

  byte_set_lookup #(
    .DATA_W    (DATA_W),
    .SET_DEPTH (SET_DEPTH)
  ) u_lookup (
    .data    (in_data),
    .set_val (set_val),
    .set_vld (set_vld),
    .hit_c   (hit_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and per-cycle strobes
  always_comb begin
    state_n       = state;
    accept_c      = 1'b0;
    last_c        = 1'b0;
    frame_start_c = 1'b0;
    cfg_open_c    = 1'b0;
    case (state)
      IDLE: begin
        cfg_open_c = 1'b1;
        if (start) begin
          frame_start_c = 1'b1;
          state_n       = (frame_len != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        accept_c = in_valid;
        last_c   = in_valid && (idx_q == LEN_W'(len_q - LEN_W'(1)));
        if (last_c) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Status flags follow the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_n == SCAN);
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
    end
  end

  // Set storage; writable only while idle so a frame always sees a stable set
  always_ff @(posedge clk) begin
    if (rst) begin
      set_vld <= '0;
      set_val <= '0;
    end else if (cfg_open_c) begin
      if (cfg_clr) begin
        set_vld <= '0;
      end else if (cfg_we) begin
        set_vld[cfg_idx] <= 1'b1;
        set_val[cfg_idx] <= cfg_val;
      end
    end
  end

  // Frame datapath: byte index, hit counter and first-hit capture
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q         <= '0;
      idx_q         <= '0;
      match_out     <= 1'b0;
      hit_count     <= '0;
      first_hit_idx <= '0;
      first_hit_vld <= 1'b0;
    end else begin
      match_out <= accept_c && hit_c;
      if (frame_start_c) begin
        len_q         <= frame_len;
        idx_q         <= '0;
        hit_count     <= '0;
        first_hit_idx <= '0;
        first_hit_vld <= 1'b0;
      end else if (accept_c) begin
        idx_q <= LEN_W'(idx_q + LEN_W'(1));
        if (hit_c) begin
          if (hit_count != {CNT_W{1'b1}}) begin
            hit_count <= CNT_W'(hit_count + CNT_W'(1));
          end
          if (!first_hit_vld) begin
            first_hit_vld <= 1'b1;
            first_hit_idx <= idx_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_set_scanner.sv
// Self-checking bench for byte_set_scanner: frame vectors plus a match_out scoreboard.
module tb_byte_set_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we, cfg_clr;
  logic [2:0] cfg_idx;
  logic [7:0] cfg_val;
  logic       start;
  logic [7:0] frame_len;
  logic       in_valid;
  logic [7:0] in_data;

  logic        in_ready, busy, match_out, first_hit_vld, done;
  logic [15:0] hit_count;
  logic [7:0]  first_hit_idx;

  logic        s_in_ready, s_busy, s_match_out, s_first_hit_vld, s_done;
  logic [1:0]  s_hit_count;
  logic [7:0]  s_first_hit_idx;

  byte_set_scanner dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_idx(cfg_idx),
    .cfg_val(cfg_val), .start(start), .frame_len(frame_len), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .busy(busy), .match_out(match_out),
    .hit_count(hit_count), .first_hit_idx(first_hit_idx),
    .first_hit_vld(first_hit_vld), .done(done)
  );

  byte_set_scanner #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_clr(cfg_clr), .cfg_idx(cfg_idx),
    .cfg_val(cfg_val), .start(start), .frame_len(frame_len), .in_valid(in_valid),
    .in_data(in_data), .in_ready(s_in_ready), .busy(s_busy), .match_out(s_match_out),
    .hit_count(s_hit_count), .first_hit_idx(s_first_hit_idx),
    .first_hit_vld(s_first_hit_vld), .done(s_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       m;
  } vec_t;

  vec_t base_tbl[5];
  vec_t frame_q[$];
  logic sb_q[$];
  logic cur_exp = 1'b0;
  logic acc_d = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   done_cnt = 0;
  int   ready_drop = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endfunction

  // Scoreboard: expectation queued on accept, compared one cycle later
  always @(posedge clk) begin
    acc_d <= in_valid && in_ready && !rst;
    if (in_valid && in_ready && !rst) sb_q.push_back(cur_exp);
  end

  always @(negedge clk) begin
    if (acc_d) begin
      if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 1);
      else chk("match_out", 32'(match_out), 32'(sb_q.pop_front()));
    end
    if (done) done_cnt++;
    if (busy && !done && !in_ready) ready_drop++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [7:0] val);
    cfg_we = 1'b1; cfg_idx = idx; cfg_val = val;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_clear;
    cfg_clr = 1'b1;
    tick;
    cfg_clr = 1'b0;
  endtask

  task automatic do_start(input int len);
    start = 1'b1; frame_len = 8'(len);
    tick;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic m);
    int n = 0;
    in_valid = 1'b1; in_data = d; cur_exp = m;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    chk("accept_wait", 32'(in_ready), 1);
    tick;
    in_valid = 1'b0;
  endtask

  // Called right after the last accept edge (or the zero-length start edge)
  task automatic finish_frame(input string tag, input int hits, input logic fvld, input int first);
    int sat;
    sat = (hits > 3) ? 3 : hits;
    chk({tag, "_done_early"}, 32'(done_cnt), 0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_ready_in_done"}, 32'(in_ready), 0);
    chk({tag, "_hit_count"}, 32'(hit_count), 32'(hits));
    chk({tag, "_sat_hit_count"}, 32'(s_hit_count), 32'(sat));
    chk({tag, "_first_vld"}, 32'(first_hit_vld), 32'(fvld));
    if (fvld) chk({tag, "_first_idx"}, 32'(first_hit_idx), 32'(first));
    tick;
    chk({tag, "_done_width"}, 32'(done), 0);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_done_count"}, 32'(done_cnt), 1);
    chk({tag, "_hold_hits"}, 32'(hit_count), 32'(hits));
  endtask

  task automatic run_frame(input string tag, input int gap, input int hits,
                           input logic fvld, input int first);
    done_cnt = 0;
    do_start(frame_q.size());
    for (int i = 0; i < frame_q.size(); i++) begin
      send(frame_q[i].d, frame_q[i].m);
      if (i != frame_q.size() - 1) repeat (gap) tick;
    end
    finish_frame(tag, hits, fvld, first);
  endtask

  task automatic fill(input logic [7:0] d, input logic m, input int n);
    for (int i = 0; i < n; i++) frame_q.push_back('{d: d, m: m});
  endtask

  initial begin
    base_tbl = '{'{8'h11, 1'b1}, '{8'h05, 1'b0}, '{8'hAA, 1'b1},
                 '{8'h22, 1'b1}, '{8'h00, 1'b0}};
    rst = 1'b1; cfg_we = 1'b0; cfg_clr = 1'b0; cfg_idx = '0; cfg_val = '0;
    start = 1'b0; frame_len = '0; in_valid = 1'b0; in_data = '0;
    tick; tick;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_match", 32'(match_out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_first_vld", 32'(first_hit_vld), 0);
    chk("rst_first_idx", 32'(first_hit_idx), 0);
    tick;
    rst = 1'b0;

    // Basic frame, back-to-back bytes
    cfg_write(3'd0, 8'h11); cfg_write(3'd1, 8'h22); cfg_write(3'd2, 8'hAA);
    frame_q.delete();
    foreach (base_tbl[i]) frame_q.push_back(base_tbl[i]);
    run_frame("basic", 0, 3, 1'b1, 0);

    // Same frame with 3-cycle valid gaps
    ready_drop = 0;
    run_frame("gaps", 3, 3, 1'b1, 0);
    chk("gaps_ready_steady", 32'(ready_drop), 0);

    // Zero-length frame
    frame_q.delete();
    run_frame("zero", 0, 0, 1'b0, 0);

    // Cleared set never matches; then a single entry of 0x00
    cfg_clear;
    frame_q.delete(); fill(8'h00, 1'b0, 4);
    run_frame("cleared", 0, 0, 1'b0, 0);
    cfg_write(3'd3, 8'h00);
    frame_q.delete(); fill(8'h00, 1'b1, 4);
    run_frame("zero_entry", 0, 4, 1'b1, 0);
    frame_q.delete(); fill(8'h00, 1'b1, 6);
    run_frame("saturate", 0, 6, 1'b1, 0);

    // Clear and write in the same cycle: clear wins
    cfg_clr = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0; cfg_val = 8'h77;
    tick;
    cfg_clr = 1'b0; cfg_we = 1'b0;
    frame_q.delete(); fill(8'h77, 1'b0, 1); fill(8'h00, 1'b0, 1);
    run_frame("clr_wins", 0, 0, 1'b0, 0);

    // Start together with a write: frame sees the new entry
    cfg_write(3'd1, 8'h11);
    done_cnt = 0;
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_val = 8'h06; start = 1'b1; frame_len = 8'd4;
    tick;
    cfg_we = 1'b0; start = 1'b0;
    send(8'h05, 1'b0); send(8'h06, 1'b1); send(8'h11, 1'b1); send(8'h11, 1'b1);
    finish_frame("start_we", 3, 1'b1, 1);

    // Writes and start are ignored while scanning
    done_cnt = 0;
    do_start(3);
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_val = 8'h55; start = 1'b1; frame_len = 8'd1;
    tick;
    cfg_we = 1'b0; start = 1'b0;
    send(8'h55, 1'b0); send(8'h11, 1'b1); send(8'h55, 1'b0);
    finish_frame("busy_cfg", 1, 1'b1, 1);

    // Reset mid-frame: no done, everything cleared, set invalidated
    done_cnt = 0;
    do_start(4);
    send(8'h11, 1'b1); send(8'h22, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_match", 32'(match_out), 0);
    chk("mid_rst_hit_count", 32'(hit_count), 0);
    chk("mid_rst_first_vld", 32'(first_hit_vld), 0);
    chk("mid_rst_first_idx", 32'(first_hit_idx), 0);
    repeat (3) tick;
    chk("mid_rst_no_done", 32'(done_cnt), 0);
    frame_q.delete(); fill(8'h11, 1'b0, 1); fill(8'h06, 1'b0, 1);
    run_frame("after_rst", 0, 0, 1'b0, 0);

    repeat (2) tick;
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
